// File: rtl/serial_bus_pkg.sv
// Shared types and helpers for the serial bus arbiter.
package serial_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RESUME
    } arb_state_t;

    localparam int TIMEOUT_DEFAULT = 64;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_bus_arbiter_pick.sv
// Masked round-robin picker: first unmasked requester at or after rr_ptr.
module rr_priority_pick
    import serial_bus_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] rr_ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin : pick
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j] && !mask[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin serial bus arbiter with one outstanding split
// transaction and an idle-bus watchdog.
module serial_bus_arbiter
    import serial_bus_pkg::*;
#(
    parameter int N_INIT  = 2,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_INIT-1:0]         req,
    input  logic                      target_split,
    input  logic                      split_done,
    input  logic                      target_ack,
    input  logic                      bus_valid,
    output logic [N_INIT-1:0]         grant,
    output logic                      grant_valid,
    output logic [$clog2(N_INIT)-1:0] grant_idx,
    output logic                      split_pending,
    output logic [$clog2(N_INIT)-1:0] split_owner,
    output logic                      timeout,
    output logic                      split_err
);

    localparam int IW = idx_w(N_INIT);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    arb_state_t      state_q, state_d;
    logic [N_INIT-1:0] grant_q, grant_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            ready_q, ready_d;
    logic            timeout_q, timeout_d;
    logic            err_q, err_d;

    logic [IW-1:0]     cur_idx;
    logic [N_INIT-1:0] mask;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic              activity;
    logic              wd_fire;
    logic              release_bus;
    logic              new_split;
    logic              resume_go;

    always_comb begin
        cur_idx = '0;
        for (int k = 0; k < N_INIT; k++) begin
            if (grant_q[k]) cur_idx = IW'(k);
        end
    end

    // A parked split owner may only come back through the resume path.
    always_comb begin
        mask = '0;
        if (pend_q) mask[owner_q] = 1'b1;
    end

    rr_priority_pick #(
        .N  (N_INIT),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .mask   (mask),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    assign activity = bus_valid | target_ack;
    assign wd_fire  = !activity && (cnt_q == CNT_MAX);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        owner_d     = owner_q;
        ready_d     = ready_q;
        timeout_d   = 1'b0;
        err_d       = 1'b0;
        release_bus = 1'b0;
        new_split   = 1'b0;
        resume_go   = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pend_q && ready_q) begin
                    resume_go      = 1'b1;
                    grant_d        = '0;
                    grant_d[owner_q] = 1'b1;
                    state_d        = RESUME;
                    pend_d         = 1'b0;
                    ready_d        = 1'b0;
                end else if (pick_found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    state_d           = GRANT;
                    if (pick_idx == IW'(N_INIT - 1))
                        rr_ptr_d = '0;
                    else
                        rr_ptr_d = pick_idx + IW'(1);
                end
            end
            GRANT: begin
                if (activity)            cnt_d = '0;
                else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                if (target_split) begin
                    release_bus = 1'b1;
                    if (!pend_q) begin
                        new_split = 1'b1;
                        pend_d    = 1'b1;
                        owner_d   = cur_idx;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (!req[cur_idx]) begin
                    release_bus = 1'b1;
                end else if (wd_fire) begin
                    release_bus = 1'b1;
                    timeout_d   = 1'b1;
                end
            end
            RESUME: begin
                if (activity)            cnt_d = '0;
                else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                if (target_split) begin
                    err_d       = 1'b1;
                    release_bus = 1'b1;
                end else if (target_ack) begin
                    release_bus = 1'b1;
                end else if (wd_fire) begin
                    release_bus = 1'b1;
                    timeout_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (release_bus) begin
            grant_d = '0;
            state_d = IDLE;
            cnt_d   = '0;
        end

        // A completion racing the split that creates it still counts.
        if (split_done) begin
            if (pend_q) begin
                if (!resume_go) ready_d = 1'b1;
            end else if (new_split) begin
                ready_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            owner_q   <= '0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            owner_q   <= owner_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = |grant_q;
    assign grant_idx     = cur_idx;
    assign split_pending = pend_q;
    assign split_owner   = owner_q;
    assign timeout       = timeout_q;
    assign split_err     = err_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter (N_INIT=2, TIMEOUT=64).
module tb_serial_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic       target_split;
    logic       split_done;
    logic       target_ack;
    logic       bus_valid;
    logic [1:0] grant;
    logic       grant_valid;
    logic [0:0] grant_idx;
    logic       split_pending;
    logic [0:0] split_owner;
    logic       timeout;
    logic       split_err;

    int checks;
    int failures;

    serial_bus_arbiter #(
        .N_INIT  (2),
        .TIMEOUT (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .target_split  (target_split),
        .split_done    (split_done),
        .target_ack    (target_ack),
        .bus_valid     (bus_valid),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .split_pending (split_pending),
        .split_owner   (split_owner),
        .timeout       (timeout),
        .split_err     (split_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        req          = 2'b00;
        target_split = 1'b0;
        split_done   = 1'b0;
        target_ack   = 1'b0;
        bus_valid    = 1'b0;

        step(2);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_gvalid", 32'(grant_valid), 32'h0);
        chk("rst_pend", 32'(split_pending), 32'h0);
        chk("rst_tmo", 32'(timeout), 32'h0);
        chk("rst_err", 32'(split_err), 32'h0);
        rst_n = 1'b1;

        // basic grant / release, rr_ptr moves to 1
        step(1);
        req = 2'b01;
        step(1);
        chk("g0_grant", 32'(grant), 32'h1);
        chk("g0_valid", 32'(grant_valid), 32'h1);
        chk("g0_idx", 32'(grant_idx), 32'h0);
        step(3);
        chk("g0_hold", 32'(grant), 32'h1);
        req = 2'b00;
        step(1);
        chk("g0_rel", 32'(grant), 32'h0);

        // round robin with turnaround gap
        req = 2'b11;
        step(1);
        chk("rr_g1", 32'(grant), 32'h2);
        chk("rr_idx1", 32'(grant_idx), 32'h1);
        step(2);
        req = 2'b01;
        step(1);
        chk("rr_gap", 32'(grant), 32'h0);
        step(1);
        chk("rr_g0", 32'(grant), 32'h1);

        // split, masked owner, resume ahead of others
        target_split = 1'b1;
        step(1);
        target_split = 1'b0;
        chk("sp_rel", 32'(grant), 32'h0);
        chk("sp_pend", 32'(split_pending), 32'h1);
        chk("sp_owner", 32'(split_owner), 32'h0);
        req = 2'b11;
        step(1);
        chk("sp_other", 32'(grant), 32'h2);
        split_done = 1'b1;
        step(1);
        split_done = 1'b0;
        chk("sp_done_hold", 32'(grant), 32'h2);
        chk("sp_done_err", 32'(split_err), 32'h0);
        req = 2'b01;
        step(1);
        chk("sp_gap", 32'(grant), 32'h0);
        step(1);
        chk("sp_resume", 32'(grant), 32'h1);
        chk("sp_clr", 32'(split_pending), 32'h0);
        req = 2'b00;
        step(1);
        chk("sp_res_hold", 32'(grant), 32'h1);
        target_ack = 1'b1;
        step(1);
        target_ack = 1'b0;
        chk("sp_ack_rel", 32'(grant), 32'h0);

        // watchdog, no bus activity
        req = 2'b10;
        step(1);
        chk("wd_grant", 32'(grant), 32'h2);
        step(63);
        chk("wd_hold63", 32'(grant), 32'h2);
        chk("wd_notmo", 32'(timeout), 32'h0);
        step(1);
        chk("wd_rev", 32'(grant), 32'h0);
        chk("wd_pulse", 32'(timeout), 32'h1);
        step(1);
        chk("wd_regrant", 32'(grant), 32'h2);
        chk("wd_pulse_end", 32'(timeout), 32'h0);

        // watchdog restarted by a bus_valid blip
        step(39);
        bus_valid = 1'b1;
        step(1);
        bus_valid = 1'b0;
        step(63);
        chk("wdb_hold", 32'(grant), 32'h2);
        chk("wdb_notmo", 32'(timeout), 32'h0);
        step(1);
        chk("wdb_rev", 32'(grant), 32'h0);
        chk("wdb_pulse", 32'(timeout), 32'h1);
        req = 2'b00;

        // stray split_done
        step(1);
        split_done = 1'b1;
        step(1);
        split_done = 1'b0;
        chk("sd_err", 32'(split_err), 32'h1);
        chk("sd_pend", 32'(split_pending), 32'h0);
        chk("sd_grant", 32'(grant), 32'h0);
        step(1);
        chk("sd_err_end", 32'(split_err), 32'h0);

        // second split while one is parked
        req = 2'b01;
        step(1);
        chk("s2_g0", 32'(grant), 32'h1);
        target_split = 1'b1;
        step(1);
        target_split = 1'b0;
        chk("s2_pend", 32'(split_pending), 32'h1);
        req = 2'b11;
        step(1);
        chk("s2_g1", 32'(grant), 32'h2);
        target_split = 1'b1;
        step(1);
        target_split = 1'b0;
        chk("s2_rel", 32'(grant), 32'h0);
        chk("s2_err", 32'(split_err), 32'h1);
        chk("s2_owner", 32'(split_owner), 32'h0);
        chk("s2_pend_kept", 32'(split_pending), 32'h1);

        // async reset mid-grant with split outstanding
        req = 2'b10;
        step(1);
        chk("ar_grant", 32'(grant), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_grant0", 32'(grant), 32'h0);
        chk("ar_pend0", 32'(split_pending), 32'h0);
        chk("ar_valid0", 32'(grant_valid), 32'h0);
        step(1);
        rst_n = 1'b1;
        req   = 2'b01;
        step(1);
        chk("ar_regrant", 32'(grant), 32'h1);

        // split and split_done together, then split during resume
        target_split = 1'b1;
        split_done   = 1'b1;
        step(1);
        target_split = 1'b0;
        split_done   = 1'b0;
        chk("ss_rel", 32'(grant), 32'h0);
        chk("ss_pend", 32'(split_pending), 32'h1);
        chk("ss_noerr", 32'(split_err), 32'h0);
        req = 2'b10;
        step(1);
        chk("ss_resume", 32'(grant), 32'h1);
        chk("ss_clr", 32'(split_pending), 32'h0);
        target_split = 1'b1;
        step(1);
        target_split = 1'b0;
        chk("rs_err", 32'(split_err), 32'h1);
        chk("rs_rel", 32'(grant), 32'h0);
        step(1);
        chk("rs_next", 32'(grant), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
